// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the PPU-to-VGA scanline buffer sequencer.
package vga_pkg;

  localparam int PPU_LINE_CLKS = 1600;
  localparam int WR_PIX        = PPU_LINE_CLKS / 2;
  localparam int ADDR_W        = 10;
  localparam int PRIME_LINES   = 2;

  localparam int PHASE_W = $clog2(PPU_LINE_CLKS);
  localparam int LCNT_W  = $clog2(PRIME_LINES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2,
    RESYNC = 2'd3
  } state_t;

endpackage

// File: rtl/ppu_line_phase.sv
// Tracks the phase of each PPU input cycle within its line and flags line_start
// pulses that arrive early or go missing at the wrap.
module ppu_line_phase
  import vga_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               track,
  input  logic               line_start,
  output logic [PHASE_W-1:0] phase,
  output logic               line_ok,
  output logic               early,
  output logic               missing,
  output logic               wrap
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(PPU_LINE_CLKS - 1);

  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;

  // phase_reg holds the phase of the current input cycle; the restart cycle is p=0.
  always_comb begin
    phase_next = phase_reg;
    if (restart) begin
      phase_next = PHASE_W'(1);
    end else if (track) begin
      phase_next = (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign phase   = phase_reg;
  assign line_ok = track & line_start & (phase_reg == '0);
  assign early   = track & line_start & (phase_reg != '0);
  assign missing = track & ~line_start & (phase_reg == '0);
  assign wrap    = track & (phase_reg == LAST);

endmodule

// File: rtl/vga_linebuf_ctrl.sv
// Ping-pong scanline buffer sequencer: decimates PPU lines into buffer writes,
// alternates banks per line and gates VGA timing until enough lines are primed.
module vga_linebuf_ctrl
  import vga_pkg::*;
(
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              ppu_line_start,
  input  logic              ppu_frame_start,
  input  logic [23:0]       pix_din,
  input  logic              err_clr,
  output logic              wr_en_0,
  output logic              wr_en_1,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              rd_bank,
  output logic              vga_en,
  output logic              primed,
  output logic              err_early,
  output logic              err_missing
);

  state_t              state_reg, state_next;
  logic                bank_reg, bank_next;
  logic [LCNT_W-1:0]   lcnt_reg, lcnt_next, lcnt_inc;
  logic                wr_en_0_reg, wr_en_0_next;
  logic                wr_en_1_reg, wr_en_1_next;
  logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
  logic [23:0]         wr_data_reg;
  logic                rd_bank_reg, rd_bank_next;
  logic                vga_en_reg, vga_en_next;
  logic                err_early_reg, err_early_next;
  logic                err_missing_reg, err_missing_next;

  logic                track;
  logic                start;
  logic [PHASE_W-1:0]  phase;
  logic                line_ok;
  logic                early;
  logic                missing;
  logic                wrap;

  assign track    = (state_reg == PRIME) || (state_reg == RUN);
  assign start    = ppu_frame_start & ppu_line_start & ~track;
  assign lcnt_inc = lcnt_reg + 1'b1;

  ppu_line_phase u_phase (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .restart    (start),
    .track      (track),
    .line_start (ppu_line_start),
    .phase      (phase),
    .line_ok    (line_ok),
    .early      (early),
    .missing    (missing),
    .wrap       (wrap)
  );

  always_comb begin
    state_next   = state_reg;
    bank_next    = bank_reg;
    lcnt_next    = lcnt_reg;
    wr_en_0_next = 1'b0;
    wr_en_1_next = 1'b0;
    wr_addr_next = wr_addr_reg;
    rd_bank_next = rd_bank_reg;

    if (start) begin
      // Frame start: p=0 of line 0, written to bank 0.
      state_next   = PRIME;
      bank_next    = 1'b0;
      lcnt_next    = '0;
      wr_en_0_next = 1'b1;
      wr_addr_next = '0;
      rd_bank_next = 1'b1;
    end else if (track) begin
      if (early || missing) begin
        state_next = RESYNC;
      end else begin
        if (!phase[0]) begin
          wr_en_0_next = ~bank_reg;
          wr_en_1_next = bank_reg;
          wr_addr_next = ADDR_W'(phase >> 1);
        end
        rd_bank_next = ~bank_reg;
        if (wrap) begin
          bank_next = ~bank_reg;
        end
        if (line_ok && (state_reg == PRIME)) begin
          lcnt_next = lcnt_inc;
          if (lcnt_inc == LCNT_W'(PRIME_LINES)) begin
            state_next = RUN;
          end
        end
      end
    end

    vga_en_next      = (state_next == RUN);
    // A new error outranks a clear arriving in the same cycle.
    err_early_next   = early | (err_early_reg & ~err_clr);
    err_missing_next = missing | (err_missing_reg & ~err_clr);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      bank_reg        <= 1'b0;
      lcnt_reg        <= '0;
      wr_en_0_reg     <= 1'b0;
      wr_en_1_reg     <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      rd_bank_reg     <= 1'b0;
      vga_en_reg      <= 1'b0;
      err_early_reg   <= 1'b0;
      err_missing_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bank_reg        <= bank_next;
      lcnt_reg        <= lcnt_next;
      wr_en_0_reg     <= wr_en_0_next;
      wr_en_1_reg     <= wr_en_1_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= pix_din;
      rd_bank_reg     <= rd_bank_next;
      vga_en_reg      <= vga_en_next;
      err_early_reg   <= err_early_next;
      err_missing_reg <= err_missing_next;
    end
  end

  assign wr_en_0     = wr_en_0_reg;
  assign wr_en_1     = wr_en_1_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign rd_bank     = rd_bank_reg;
  assign vga_en      = vga_en_reg;
  assign primed      = vga_en_reg;
  assign err_early   = err_early_reg;
  assign err_missing = err_missing_reg;

endmodule

// File: tb/tb_vga_linebuf_ctrl.sv
// Directed bench for vga_linebuf_ctrl: startup priming, bank alternation,
// early/missing line_start recovery, sticky error flags and async reset.
module tb_vga_linebuf_ctrl;
  import vga_pkg::*;

  logic              pclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ppu_line_start = 1'b0;
  logic              ppu_frame_start = 1'b0;
  logic [23:0]       pix_din = '0;
  logic              err_clr = 1'b0;
  logic              wr_en_0, wr_en_1;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              rd_bank, vga_en, primed, err_early, err_missing;

  logic [38:0]       obs;
  int                n_cmp = 0;
  int                n_bad = 0;

  assign obs = {wr_en_0, wr_en_1, wr_addr, wr_data, rd_bank, vga_en, primed};

  vga_linebuf_ctrl dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .ppu_line_start  (ppu_line_start),
    .ppu_frame_start (ppu_frame_start),
    .pix_din         (pix_din),
    .err_clr         (err_clr),
    .wr_en_0         (wr_en_0),
    .wr_en_1         (wr_en_1),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_bank         (rd_bank),
    .vga_en          (vga_en),
    .primed          (primed),
    .err_early       (err_early),
    .err_missing     (err_missing)
  );

  always #5 pclk = ~pclk;

  function automatic logic [23:0] pix_of(input int line, input int p);
    return 24'(line * 4099 + p * 7 + 32'h00A5C3E1);
  endfunction

  // Apply one input cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic ls, input logic fs, input logic clr, input logic [23:0] pix);
    ppu_line_start  = ls;
    ppu_frame_start = fs;
    err_clr         = clr;
    pix_din         = pix;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({obs, err_early, err_missing} !== 41'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {obs, err_early, err_missing});
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'd0);
    drive(1'b1, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 1'b0, 24'd0);
    n_cmp++;
    if ({obs, err_early, err_missing} !== 41'd0) begin
      n_bad++;
      $display("FAIL idle_ignore: got %h want 0", {obs, err_early, err_missing});
    end
    $display("reset: outputs %h", obs);
  endtask

  task automatic test_startup();
    int s0, s1;
    logic b, ev;
    logic [38:0] exp;
    for (int k = 0; k < 2; k++) begin
      s0 = 0;
      s1 = 0;
      b  = k[0];
      for (int p = 0; p < PPU_LINE_CLKS; p++) begin
        drive(p == 0, (k == 0) && (p == 0), 1'b0, pix_of(k, p));
        ev  = (p % 2 == 0);
        exp = {ev & ~b, ev & b, ADDR_W'(p / 2), pix_of(k, p), ~b, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          if (n_bad < 20) $display("FAIL startup l%0d p%0d: got %h want %h", k, p, obs, exp);
        end
        s0 += int'(wr_en_0);
        s1 += int'(wr_en_1);
      end
      n_cmp++;
      if (s0 != (b ? 0 : WR_PIX) || s1 != (b ? WR_PIX : 0)) begin
        n_bad++;
        $display("FAIL startup_strobes l%0d: got %0d/%0d", k, s0, s1);
      end
      $display("startup line %0d bank %0d strobes %0d/%0d", k, b, s0, s1);
    end
    drive(1'b1, 1'b0, 1'b0, pix_of(2, 0));
    exp = {1'b1, 1'b0, ADDR_W'(0), pix_of(2, 0), 1'b1, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL vga_en_rise: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_run();
    int s0, s1;
    logic b, ev;
    logic [38:0] exp;
    for (int k = 2; k < 8; k++) begin
      s0 = (k == 2) ? 1 : 0;
      s1 = 0;
      b  = k[0];
      for (int p = (k == 2) ? 1 : 0; p < PPU_LINE_CLKS; p++) begin
        drive(p == 0, 1'b0, 1'b0, pix_of(k, p));
        ev  = (p % 2 == 0);
        exp = {ev & ~b, ev & b, ADDR_W'(p / 2), pix_of(k, p), ~b, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          if (n_bad < 20) $display("FAIL run l%0d p%0d: got %h want %h", k, p, obs, exp);
        end
        s0 += int'(wr_en_0);
        s1 += int'(wr_en_1);
      end
      n_cmp++;
      if (s0 != (b ? 0 : WR_PIX) || s1 != (b ? WR_PIX : 0)) begin
        n_bad++;
        $display("FAIL run_strobes l%0d: got %0d/%0d", k, s0, s1);
      end
      $display("run line %0d bank %0d strobes %0d/%0d", k, b, s0, s1);
    end
  endtask

  task automatic test_frame_only();
    logic b, ev, fs;
    logic [38:0] exp;
    for (int k = 8; k < 10; k++) begin
      b = k[0];
      for (int p = 0; p < PPU_LINE_CLKS; p++) begin
        fs = ((k == 8) && (p == 500)) || ((k == 9) && (p == 0));
        drive(p == 0, fs, 1'b0, pix_of(k, p));
        ev  = (p % 2 == 0);
        exp = {ev & ~b, ev & b, ADDR_W'(p / 2), pix_of(k, p), ~b, 1'b1, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          if (n_bad < 20) $display("FAIL frame_only l%0d p%0d: got %h want %h", k, p, obs, exp);
        end
      end
    end
    n_cmp++;
    if ({err_early, err_missing} !== 2'b00) begin
      n_bad++;
      $display("FAIL frame_only_flags: got %b want 00", {err_early, err_missing});
    end
    $display("frame_only: lines 8-9 done, flags %b", {err_early, err_missing});
  endtask

  task automatic test_early();
    int strobes;
    logic b, ev, v;
    logic [38:0] exp;
    for (int p = 0; p < 1000; p++) drive(p == 0, 1'b0, 1'b0, pix_of(10, p));
    drive(1'b1, 1'b0, 1'b0, pix_of(10, 1000));
    n_cmp++;
    if ({wr_en_0, wr_en_1, vga_en, primed, err_early, err_missing} !== 6'b000010) begin
      n_bad++;
      $display("FAIL early_detect: got %b want 000010",
               {wr_en_0, wr_en_1, vga_en, primed, err_early, err_missing});
    end
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      drive(i == 20, 1'b0, 1'b0, 24'd0);
      strobes += int'(wr_en_0) + int'(wr_en_1) + int'(vga_en);
    end
    n_cmp++;
    if (strobes != 0) begin
      n_bad++;
      $display("FAIL resync_quiet: got %0d strobes want 0", strobes);
    end
    for (int k = 0; k < 3; k++) begin
      b = k[0];
      v = (k == 2);
      for (int p = 0; p < ((k == 2) ? 1 : PPU_LINE_CLKS); p++) begin
        drive(p == 0, (k == 0) && (p == 0), 1'b0, pix_of(k + 20, p));
        ev  = (p % 2 == 0);
        exp = {ev & ~b, ev & b, ADDR_W'(p / 2), pix_of(k + 20, p), ~b, v, v};
        n_cmp++;
        if (obs !== exp) begin
          n_bad++;
          if (n_bad < 20) $display("FAIL recover l%0d p%0d: got %h want %h", k, p, obs, exp);
        end
      end
    end
    n_cmp++;
    if (err_early !== 1'b1) begin
      n_bad++;
      $display("FAIL early_sticky: got %b want 1", err_early);
    end
    $display("early: recovered, vga_en %b err_early %b", vga_en, err_early);
  endtask

  task automatic test_missing();
    logic ev;
    logic [38:0] exp;
    for (int p = 1; p < PPU_LINE_CLKS; p++) begin
      drive(1'b0, 1'b0, p == 5, pix_of(30, p));
      ev  = (p % 2 == 0);
      exp = {ev, 1'b0, ADDR_W'(p / 2), pix_of(30, p), 1'b1, 1'b1, 1'b1};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        if (n_bad < 20) $display("FAIL pre_missing p%0d: got %h want %h", p, obs, exp);
      end
      if (p == 5) begin
        n_cmp++;
        if (err_early !== 1'b0) begin
          n_bad++;
          $display("FAIL err_clr_early: got %b want 0", err_early);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 24'd0);
    n_cmp++;
    if ({wr_en_0, wr_en_1, vga_en, err_early, err_missing} !== 5'b00001) begin
      n_bad++;
      $display("FAIL missing_detect: got %b want 00001",
               {wr_en_0, wr_en_1, vga_en, err_early, err_missing});
    end
    drive(1'b0, 1'b0, 1'b1, 24'd0);
    n_cmp++;
    if (err_missing !== 1'b0) begin
      n_bad++;
      $display("FAIL err_clr_missing: got %b want 0", err_missing);
    end
    drive(1'b1, 1'b1, 1'b0, pix_of(31, 0));
    n_cmp++;
    if ({wr_en_0, wr_en_1, wr_addr, vga_en} !== {2'b10, ADDR_W'(0), 1'b0}) begin
      n_bad++;
      $display("FAIL missing_restart: got %b%b %0d %b want 10 0 0", wr_en_0, wr_en_1, wr_addr, vga_en);
    end
    for (int p = 1; p < 10; p++) drive(1'b0, 1'b0, 1'b0, pix_of(31, p));
    drive(1'b1, 1'b0, 1'b1, pix_of(31, 10));
    n_cmp++;
    if ({wr_en_0, wr_en_1, err_early, err_missing} !== 4'b0010) begin
      n_bad++;
      $display("FAIL clr_vs_error: got %b want 0010", {wr_en_0, wr_en_1, err_early, err_missing});
    end
    $display("missing: flags %b", {err_early, err_missing});
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, pix_of(40, 0));
    for (int p = 1; p < 300; p++) drive(1'b0, 1'b0, 1'b0, pix_of(40, p));
    n_cmp++;
    if (wr_en_0 !== 1'b0 || wr_addr !== ADDR_W'(149)) begin
      n_bad++;
      $display("FAIL pre_reset: got %b %0d want 0 149", wr_en_0, wr_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs, err_early, err_missing} !== 41'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0", {obs, err_early, err_missing});
    end
    @(posedge pclk);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b1, 1'b0, 24'd0);
    drive(1'b1, 1'b0, 1'b0, 24'd0);
    n_cmp++;
    if ({wr_en_0, wr_en_1, rd_bank, vga_en, primed} !== 5'b00000) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %b want 00000", {wr_en_0, wr_en_1, rd_bank, vga_en, primed});
    end
    $display("async_reset: outputs %h", obs);
  endtask

  initial begin
    test_reset();
    test_startup();
    test_run();
    test_frame_only();
    test_early();
    test_missing();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_linebuf_ctrl.md
Name: vga_linebuf_ctrl

Overview:
- Sequencer for the ping-pong scanline buffers between the PPU pixel stream and the VGA/TMDS output path.
- Locks to PPU line/frame pulses and decimates the 1600-clock PPU line to 800 buffer writes.
- Alternates write banks per PPU line and gates VGA timing (vga_en) until enough lines are primed.
- Detects PPU line-sync loss and resynchronises at the next PPU frame start.

Parameters:
- PPU_LINE_CLKS, 1600: pclk cycles per PPU line; must be even.
- WR_PIX, 800: writes per line; equals PPU_LINE_CLKS/2.
- ADDR_W, 10: buffer address width; 2**ADDR_W >= WR_PIX.
- PRIME_LINES, 2: complete lines written before vga_en asserts; must be >= 1.

Ports:
- pclk  in  1  pixel clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- ppu_line_start  in  1  pulse on the first pixel cycle of each PPU line
- ppu_frame_start  in  1  pulse coincident with ppu_line_start of PPU line 0
- pix_din  in  24  {blue,green,red} PPU pixel, valid every cycle
- err_clr  in  1  clears the sticky error flags
- wr_en_0  out  1  write strobe, bank 0
- wr_en_1  out  1  write strobe, bank 1
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  24  pix_din delayed 1 cycle
- rd_bank  out  1  bank the VGA side reads (always ~write bank)
- vga_en  out  1  enable to vga_timing
- primed  out  1  high in RUN
- err_early  out  1  sticky: line_start arrived before phase end
- err_missing  out  1  sticky: line_start absent at phase wrap

Behaviour:
- Reset: state IDLE, all outputs 0, bank_w=0 (rd_bank=1 is permitted in reset; define rd_bank=0 in reset via explicit register), phase=0, line count 0.
- Phase p of an input cycle: the ppu_line_start cycle is p=0, and each following cycle increments p.
- Wrap rule: the cycle after p=PPU_LINE_CLKS-1 has p=0 and must carry ppu_line_start.
- All outputs are registered. Input cycle N drives outputs at N+1.
- FSM states: IDLE, PRIME, RUN, RESYNC.
- IDLE -> PRIME on ppu_frame_start & ppu_line_start. That cycle is p=0 of line 0, bank 0.
- In PRIME/RUN, input cycles with even p produce wr_en_<bank_w>=1, wr_addr=p/2 and wr_data=pix_din at N+1.
  - This gives WR_PIX writes per line, addresses 0..WR_PIX-1.
  - The other bank's wr_en is always 0.
- bank_w toggles after the p=PPU_LINE_CLKS-1 cycle, so line k uses bank k mod 2.
- rd_bank = ~bank_w, registered with the same timing as wr_en.
- PRIME -> RUN on the p=0 cycle that starts line PRIME_LINES.
  - vga_en and primed go 1 one cycle later and stay 1 throughout RUN.
  - With defaults, vga_en rises at input cycle 3201.
- ppu_line_start with p != 0 (early) in PRIME/RUN:
  - err_early<=1, state -> RESYNC.
  - No write is issued for that cycle.
- No ppu_line_start at the wrap cycle (missing):
  - err_missing<=1, state -> RESYNC.
  - No write for that cycle.
- RESYNC: wr_en_* = 0 and vga_en = 0 from the next cycle. Exit to PRIME on ppu_frame_start & ppu_line_start; line count and bank_w reset to 0.
- ppu_frame_start without ppu_line_start is ignored in every state.
- In RUN, ppu_frame_start with a valid line_start is a normal line; bank parity continues without reset.
- err_* are sticky until err_clr. If err_clr and a new error occur in the same cycle, the error wins.
- Error flags do not block recovery.
- Async reset mid-line clears all outputs immediately (no wait for a pclk edge).

Decomposition:
- Shared package vga_pkg: PPU_LINE_CLKS, WR_PIX, ADDR_W, PRIME_LINES, state encoding (IDLE/PRIME/RUN/RESYNC).
- One sub-module, ppu_line_phase: phase counter, early/missing detection, wrap pulse.
- The parent holds the FSM, bank toggle, output registers and error flags.

Test Plan:
- Reset with rst_n=0 mid-stream -> all outputs 0 within the same cycle; stays in IDLE, ignoring line_start without frame_start.
- Startup: frame+line start at cycle 0, then line_start every 1600 cycles:
  - wr_en_0 at cycles 1,3,…,1599 with wr_addr 0..799 and wr_data = pix_din of the previous cycle.
  - wr_en_1 at 1601..3199.
  - vga_en rises at 3201.
- RUN over 6 lines -> line k writes bank k mod 2, rd_bank always opposite, exactly 800 strobes per line, no strobe on the idle bank.
- Early line_start at p=1000 in RUN -> err_early=1 and vga_en=0 at the next cycle, no further strobes; next frame+line start -> PRIME, vga_en back after 2 lines.
- Line_start withheld at the wrap -> err_missing=1 one cycle after the wrap cycle, RESYNC; err_clr -> flag 0; simultaneous err_clr and a new error -> flag 1.
- Frame_start pulse alone in RUN -> no effect on banks, counters or flags.
